// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges main-pipeline writes with long-latency
// results held in a 2-entry FIFO, with starvation forcing and a pending scoreboard.
module rf_wb_arbiter #(
    parameter int STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        async_valid,
    output logic        async_ready,
    input  logic [4:0]  async_waddr,
    input  logic [31:0] async_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending,
    output logic [1:0]  fifo_count
);

    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [4:0]    fifo_addr [2];
    logic [31:0]   fifo_data [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [CW-1:0] starve;
    logic          frc;

    logic          fifo_ne;
    logic          push;
    logic          grant_fifo;
    logic          grant_pipe;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;
    logic [CW-1:0] starve_nxt;
    logic [31:0]   pend_nxt;
    logic [1:0]    count_nxt;

    always_comb begin
        fifo_ne     = (fifo_count != 2'd0);
        async_ready = !rst && (fifo_count != 2'd2);
        push        = async_valid && async_ready;
        head_addr   = fifo_addr[rd_ptr];
        head_data   = fifo_data[rd_ptr];
        // A forced grant overrides the pipe; otherwise the pipe has priority.
        grant_fifo  = !rst && fifo_ne && (frc || !pipe_we);
        grant_pipe  = !rst && pipe_we && !grant_fifo;
        pipe_stall  = pipe_we && grant_fifo;
        count_nxt   = fifo_count + {1'b0, push} - {1'b0, grant_fifo};
    end

    always_comb begin
        starve_nxt = starve;
        if (grant_fifo || !fifo_ne)
            starve_nxt = '0;
        else if (grant_pipe)
            starve_nxt = starve + CW'(1);
    end

    // Clear for the popped entry first so a same-cycle issue to that register wins.
    always_comb begin
        pend_nxt = pending;
        if (grant_fifo)
            pend_nxt[head_addr] = 1'b0;
        if (issue_valid)
            pend_nxt[issue_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= async_waddr;
            fifo_data[wr_ptr] <= async_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pending    <= '0;
            fifo_count <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            starve     <= '0;
            frc        <= 1'b0;
        end else begin
            if (grant_pipe && pipe_waddr != 5'd0) begin
                rf_we    <= 1'b1;
                rf_waddr <= pipe_waddr;
                rf_wdata <= pipe_wdata;
            end else if (grant_fifo && head_addr != 5'd0) begin
                rf_we    <= 1'b1;
                rf_waddr <= head_addr;
                rf_wdata <= head_data;
            end else begin
                rf_we    <= 1'b0;
            end
            if (push)
                wr_ptr <= ~wr_ptr;
            if (grant_fifo)
                rd_ptr <= ~rd_ptr;
            fifo_count <= count_nxt;
            pending    <= pend_nxt;
            starve     <= starve_nxt;
            frc        <= (starve_nxt == LIM);
        end
    end

endmodule
